// File: rtl/l3_bank_arbiter.sv
// l3_bank_arbiter: round-robin arbiter and sequencer sharing the single-port
// L3 cell array between NUM_REQ requesters, with read-return routing.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   hold             freeze: no new grants, in-flight reads keep draining
//   req_valid/we     per-requester request valid / write enable
//   req_addr/wdata   packed per-requester address / write data
//   req_ready        one-hot (or zero) combinational grant
//   l3_en/we/addr/wdata   registered L3 access port
//   l3_rdata         L3 read data, valid L3_LAT cycles after a read l3_en
//   rsp_valid        one-hot registered read-response strobe
//   rsp_rdata        response data, holds when no response is active
//   rsp_err          flags a response to an out-of-range read
//   busy             any accepted read still in flight
module l3_bank_arbiter #(
    parameter int NUM_REQ    = 6,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int ADDR_LIMIT = 3600,
    parameter int L3_LAT     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       l3_en,
    output logic                       l3_we,
    output logic [ADDR_W-1:0]          l3_addr,
    output logic [DATA_W-1:0]          l3_wdata,
    input  logic [DATA_W-1:0]          l3_rdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = L3_LAT + 1;

    // Clamp so the limit always fits the (ADDR_W+1)-bit compare.
    localparam int LIM_C = (ADDR_LIMIT > (1 << ADDR_W)) ?
                           (1 << ADDR_W) : ADDR_LIMIT;

    localparam logic [ID_W:0]     N_L     = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ADDR_W:0]   LIMIT_L = (ADDR_W+1)'(LIM_C);

    // Round-robin pointer: index where the grant search starts.
    logic [ID_W-1:0] ptr;

    logic            found;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand_sum >= N_L) begin
                cand_sum = cand_sum - N_L;
            end
            cand = cand_sum[ID_W-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    // A grant is a transfer: the chosen requester is already valid.
    logic xfer;
    assign xfer = found & ~hold & rst_n;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_in;

    assign sel_addr  = req_addr[gnt_id*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[gnt_id*DATA_W +: DATA_W];
    assign sel_we    = req_we[gnt_id];
    assign sel_in    = ({1'b0, sel_addr} < LIMIT_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
    end

    // Issue stage. Out-of-range requests leave an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l3_en    <= 1'b0;
            l3_we    <= 1'b0;
            l3_addr  <= '0;
            l3_wdata <= '0;
        end else begin
            l3_en <= xfer & sel_in;
            l3_we <= xfer & sel_in & sel_we;
            if (xfer && sel_in) begin
                l3_addr  <= sel_addr;
                l3_wdata <= sel_wdata;
            end
        end
    end

    // Read tag pipe. Stage 0 lines up with l3_en; the last stage lines
    // up with l3_rdata, so the response is registered from it.
    logic [DEPTH-1:0] tag_v;
    logic [DEPTH-1:0] tag_oor;
    logic [ID_W-1:0]  tag_id [DEPTH];

    logic push;
    assign push = xfer & ~sel_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v   <= '0;
            tag_oor <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[DEPTH-2:0], push};
            tag_oor   <= {tag_oor[DEPTH-2:0], ~sel_in};
            tag_id[0] <= gnt_id;
            for (int k = 1; k < DEPTH; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    logic            out_v;
    logic            out_oor;
    logic [ID_W-1:0] out_id;

    assign out_v   = tag_v[DEPTH-1];
    assign out_oor = tag_oor[DEPTH-1];
    assign out_id  = tag_id[DEPTH-1];

    logic [NUM_REQ-1:0] rsp_oh;

    always_comb begin
        rsp_oh = '0;
        if (out_v) begin
            rsp_oh[out_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= rsp_oh;
            rsp_err   <= out_v & out_oor;
            if (out_v) begin
                rsp_rdata <= out_oor ? '0 : l3_rdata;
            end
        end
    end

    // Tag pipe is cleared asynchronously, so busy drops with rst_n.
    assign busy = |tag_v;

endmodule

// File: tb/tb_l3_bank_arbiter.sv
// tb_l3_bank_arbiter: directed and randomized checks of l3_bank_arbiter
// against a transaction-level reference model and an L3 array model.
module tb_l3_bank_arbiter;

    localparam int N   = 6;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LIM = 3600;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            l3_en;
    logic            l3_we;
    logic [AW-1:0]   l3_addr;
    logic [DW-1:0]   l3_wdata;
    logic [DW-1:0]   l3_rdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;

    l3_bank_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
        .ADDR_LIMIT(LIM), .L3_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .l3_en(l3_en), .l3_we(l3_we),
        .l3_addr(l3_addr), .l3_wdata(l3_wdata),
        .l3_rdata(l3_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, n, got, want);
        end
    endtask

    // L3 array model, driven only by the DUT's l3_* port.
    logic [DW-1:0] l3_mem [4096];
    logic [DW-1:0] hist [LAT+1];

    // Reference model state.
    typedef struct {
        int            acc;
        int            due;
        int            id;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] ref_mem [4096];
    int            mptr;
    logic          exp_en;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] last_rdata;
    logic [N-1:0]  taken;

    // Transfer decision for the current cycle, from the arbitration rules.
    task automatic arb();
        int            g;
        logic [N-1:0]  want;
        logic [AW-1:0] a;
        logic          inr;
        rsp_t          r;
        #1;
        g    = -1;
        want = '0;
        if (!rst_n) begin
            rq.delete();
            mptr       = 0;
            last_rdata = '0;
            exp_en     = 1'b0;
            check("rst_l3_en", l3_en, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_err", rsp_err, 0);
        end else if (!hold) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) want[g] = 1'b1;
        check("req_ready", req_ready, want);
        if (g >= 0) begin
            taken[g] = 1'b1;
            a        = req_addr[g*AW +: AW];
            inr      = (int'(a) < LIM);
            exp_en   = inr;
            exp_we   = req_we[g];
            exp_addr = a;
            exp_wd   = req_wdata[g*DW +: DW];
            if (!req_we[g]) begin
                r.acc  = n;
                r.due  = n + 2 + LAT;
                r.id   = g;
                r.err  = !inr;
                r.data = inr ? ref_mem[a] : '0;
                rq.push_back(r);
            end else if (inr) begin
                ref_mem[a] = exp_wd;
            end
            mptr = (g + 1) % N;
        end else if (rst_n) begin
            exp_en = 1'b0;
        end
    endtask

    // Advance to the next cycle midpoint and check registered outputs.
    task automatic step();
        logic [N-1:0] ev;
        logic         ee;
        @(negedge clk);
        n++;
        for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = (l3_en && !l3_we) ? l3_mem[l3_addr] : DW'($urandom);
        if (l3_en && l3_we) l3_mem[l3_addr] = l3_wdata;
        l3_rdata = hist[LAT];

        check("l3_en", l3_en, exp_en);
        if (exp_en) begin
            check("l3_we", l3_we, exp_we);
            check("l3_addr", l3_addr, exp_addr);
            if (exp_we) check("l3_wdata", l3_wdata, exp_wd);
        end
        ev = '0;
        ee = 1'b0;
        if (rq.size() > 0 && rq[0].due == n) begin
            ev[rq[0].id] = 1'b1;
            ee           = rq[0].err;
            last_rdata   = rq[0].data;
            void'(rq.pop_front());
        end
        check("rsp_valid", rsp_valid, ev);
        check("rsp_rdata", rsp_rdata, last_rdata);
        check("rsp_err", rsp_err, ee);
        check("busy", busy, (rq.size() > 0 && rq[0].acc < n));
        req_valid = req_valid & ~taken;
        taken     = '0;
    endtask

    task automatic tick();
        arb();
        step();
    endtask

    task automatic set_req(int i, logic we, int a, int d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = DW'(d);
    endtask

    task automatic new_reqs(int pct);
        int a;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(99) < pct) begin
                case ($urandom_range(9))
                    0:       a = $urandom_range(4095, LIM);
                    1:       a = $urandom_range(LIM - 1);
                    default: a = $urandom_range(31);
                endcase
                set_req(i, 1'($urandom_range(1)), a, $urandom);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            l3_mem[a]  = DW'(a * 37 + 5);
            ref_mem[a] = DW'(a * 37 + 5);
        end
        for (int k = 0; k <= LAT; k++) hist[k] = '0;
        l3_rdata   = '0;
        mptr       = 0;
        exp_en     = 1'b0;
        exp_we     = 1'b0;
        exp_addr   = '0;
        exp_wd     = '0;
        last_rdata = '0;
        taken      = '0;
        rst_n      = 1'b0;
        hold       = 1'b0;
        req_valid  = '1;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset with every requester valid.
        tick();
        tick();
        rst_n = 1'b1;

        // Round robin with all requesters reading.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, i * 16 + c, 0);
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Read latency with a known word.
        l3_mem['h123]  = 16'hBEEF;
        ref_mem['h123] = 16'hBEEF;
        set_req(3, 1'b0, 'h123, 0);
        tick();
        repeat (5) tick();

        // Address range boundaries.
        set_req(2, 1'b0, 3600, 0);
        tick();
        set_req(2, 1'b1, 4000, 'h5555);
        tick();
        set_req(2, 1'b0, 3599, 0);
        tick();
        set_req(2, 1'b1, 3599, 'h1234);
        tick();
        set_req(2, 1'b0, 3599, 0);
        tick();
        repeat (5) tick();

        // Hold freezes grants but not the read pipeline.
        set_req(4, 1'b0, 10, 0);
        tick();
        hold = 1'b1;
        set_req(1, 1'b0, 11, 0);
        set_req(5, 1'b0, 12, 0);
        repeat (5) tick();
        hold = 1'b0;
        tick();
        tick();
        repeat (5) tick();

        // Reset with reads in flight.
        set_req(0, 1'b0, 1, 0);
        tick();
        set_req(1, 1'b0, 2, 0);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(399) == 0) rst_n = 1'b0;
            hold = ($urandom_range(9) == 0);
            new_reqs(40);
            tick();
        end

        rst_n     = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l3_bank_arbiter.md
# l3_bank_arbiter

Round-robin arbiter and sequencer that shares the single-port central L3 cell array between the per-core datapath requesters. It accepts at most one request per cycle and issues it to the L3 port one cycle later. It tracks in-flight reads through the fixed L3 read latency and returns each read result to the requester that issued it. It sits between the core blocks and the L3 array.

## Interface
- NUM_REQ, 6: number of requesters (cores); supported range 2–8.
- ADDR_W, 12: L3 word address width.
- DATA_W, 16: L3 word width.
- ADDR_LIMIT, 3600: number of populated L3 words; valid addresses are 0..ADDR_LIMIT-1.
- L3_LAT, 2: cycles from `l3_en` (read) until `l3_rdata` is valid; range 1–4.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  config freeze. While high, no new grants are issued; the in-flight pipeline keeps draining.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, packed the same way as `req_addr`.
- req_ready  out  NUM_REQ  one-hot or zero grant; combinational from `req_valid`, `hold` and the pointer.
- l3_en  out  1  L3 access strobe, registered.
- l3_we  out  1  L3 write enable, registered.
- l3_addr  out  ADDR_W  L3 address, registered.
- l3_wdata  out  DATA_W  L3 write data, registered.
- l3_rdata  in  DATA_W  L3 read data; valid exactly L3_LAT cycles after a read `l3_en`.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe, registered.
- rsp_rdata  out  DATA_W  response data; holds its last value when no response is active.
- rsp_err  out  1  pulses together with `rsp_valid` for an out-of-range read.
- busy  out  1  high while any accepted read has not yet responded.

## Operation
- **Grant selection.**
  - A round-robin pointer `ptr` (0..NUM_REQ-1) is reset to 0.
  - The search for a grant starts at index `ptr` and wraps through NUM_REQ-1 back to 0.
  - `req_ready[i]`=1 for the first index i found with `req_valid[i]`=1, provided `hold`=0. All other bits are 0.
- **Handshake.** A transfer occurs when `req_valid[i]` and `req_ready[i]` are both high. Requesters must hold their valid, we, addr and wdata stable until the transfer.
- **Pointer update.**
  - After a transfer from requester i, `ptr` becomes (i+1) mod NUM_REQ.
  - With no transfer, `ptr` is unchanged.
  - `hold` never moves `ptr`.
- **Fairness.** A continuously valid requester is granted within NUM_REQ cycles of `hold` being low.
- **Issue stage.**
  - The transferred request is registered onto `l3_*`.
  - In-range requests (addr < ADDR_LIMIT) drive `l3_en`=1 for exactly one cycle.
  - Out-of-range requests drive `l3_en`=0 for that slot.
  - In-range writes have no response.
  - Out-of-range writes are dropped silently.
- **Read tracking.**
  - Each accepted read pushes {requester id, out-of-range flag} into a tag pipe NUM_REQ-agnostic and L3_LAT+1 stages deep.
  - When a read's tag leaves the pipe, `rsp_valid[id]`=1 and `rsp_rdata` is registered:
    - in-range: `rsp_rdata` = `l3_rdata`, `rsp_err`=0.
    - out-of-range: `rsp_rdata` = 0, `rsp_err`=1.
- **busy.** High when any tag-pipe stage holds a read.
- **Reset.**
  - Asserting `rst_n` low at any time clears `ptr`, the tag pipe and all registered outputs.
  - In-flight reads are discarded and produce no response.
  - Reset values: `l3_en`=0, `l3_we`=0, `l3_addr`=0, `l3_wdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
  - `req_ready` is 0 in reset.

## Timing
- Request transferred in cycle T → `l3_en` (or the empty slot for out-of-range) in cycle T+1.
- Read data sampled at T+1+L3_LAT → `rsp_valid`/`rsp_rdata` at T+2+L3_LAT. The default is T+4.
- Throughput is one request per cycle. Back-to-back reads from different requesters return in issue order, one per cycle.
- A requester may issue a new request in the same cycle it receives a response. Responses and new grants are independent.
- A write followed by a read to the same address in consecutive cycles returns the new data. This relies on the L3 array applying writes in order; the arbiter does not forward.

## Test plan
- **Reset.** Drive `rst_n` low with all `req_valid` high → `req_ready`=0, `l3_en`=0, `rsp_valid`=0, `busy`=0. Release reset with `req_valid`=6'b111111 → first grant goes to requester 0.
- **Round robin.** Hold all six requesters valid with reads for 12 cycles → grant order 0,1,2,3,4,5,0,1,2,3,4,5. Each `rsp_valid` bit appears exactly 4 cycles after its grant.
- **Read latency.** Requester 3 reads address 0x123. The L3 model returns 0xBEEF at T+3 → `rsp_valid`=6'b001000 and `rsp_rdata`=0xBEEF at T+4, `rsp_err`=0.
- **Out-of-range.**
  - Requester 2 reads address 3600 → `l3_en` stays 0. At T+4, `rsp_valid[2]`=1, `rsp_rdata`=0, `rsp_err`=1.
  - Requester 2 writes address 4000 → no `l3_en` and no response.
- **Hold and pointer.**
  - Grant requester 4, then assert `hold` for 5 cycles with requesters 1 and 5 valid → no grants during `hold`; an earlier read still responds.
  - Deassert `hold` → requester 5 is granted first, then requester 1.
- **Reset mid-flight.** Issue reads from requesters 0 and 1, then assert reset at T+2 → no `rsp_valid` ever appears for them, and `busy`=0 immediately.
